// File: rtl/image_byte_loader_pkg.sv
// Shared types for the image byte loader: loader state codes, default widths
// and the last-byte test used by the load FSM.
package image_byte_loader_pkg;

  localparam int ADDR_W_DEF = 16;
  localparam int LEN_W_DEF  = 16;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOAD  = 2'd1,
    ST_FLUSH = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

  // True when accepting one more byte completes an image of len bytes.
  function automatic logic last_beat(input logic [31:0] cnt, input logic [31:0] len);
    return ((cnt + 32'd1) == len);
  endfunction

endpackage

// File: rtl/image_byte_loader_mem_wr_stage.sv
// Registered memory write port: one byte-wide write per cycle, issued the
// cycle after the loader accepts the byte.
module mem_wr_stage #(
  parameter int ADDR_W = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              we_i,
  input  logic [ADDR_W-1:0] addr_i,
  input  logic [7:0]        din_i,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [7:0]        mem_din
);

  logic              we_q;
  logic [ADDR_W-1:0] addr_q;
  logic [7:0]        din_q;

  // Write stage register; reset drops any pending write.
  always_ff @(posedge clk) begin
    if (rst) begin
      we_q   <= 1'b0;
      addr_q <= {ADDR_W{1'b0}};
      din_q  <= 8'h00;
    end else begin
      we_q   <= we_i;
      addr_q <= addr_i;
      din_q  <= din_i;
    end
  end

  assign mem_we   = we_q;
  assign mem_addr = addr_q;
  assign mem_din  = din_q;

endmodule

// File: rtl/image_byte_loader.sv
// Writes a valid/ready pixel byte stream into the image data memory at
// consecutive (wrapping) addresses and flags done once the image is stored.
module image_byte_loader
  import image_byte_loader_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int LEN_W  = LEN_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              abort,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [LEN_W-1:0]  length,
  input  logic              s_valid,
  input  logic [7:0]        s_data,
  output logic              s_ready,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [7:0]        mem_din,
  output logic              busy,
  output logic              done,
  output logic [LEN_W-1:0]  count
);

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] base_q, base_d;
  logic [LEN_W-1:0]  len_q, len_d;
  logic [LEN_W-1:0]  count_q, count_d;
  logic              ready_q, ready_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;

  logic              xfer_s;
  logic              wr_we_s;
  logic [ADDR_W-1:0] wr_addr_s;

  // Next-state, counter and write-request logic for the load FSM.
  always_comb begin
    state_d = state_q;
    base_d  = base_q;
    len_d   = len_q;
    count_d = count_q;
    xfer_s  = s_valid && ready_q;

    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (abort) begin
          state_d = ST_IDLE;
        end else if (start) begin
          base_d  = base_addr;
          len_d   = length;
          count_d = {LEN_W{1'b0}};
          state_d = (length == {LEN_W{1'b0}}) ? ST_DONE : ST_LOAD;
        end else begin
          state_d = state_q;
        end
      end
      ST_LOAD: begin
        // A byte accepted alongside abort is still counted and written.
        if (xfer_s) begin
          count_d = count_q + {{(LEN_W-1){1'b0}}, 1'b1};
        end else begin
          count_d = count_q;
        end
        if (abort) begin
          state_d = ST_IDLE;
        end else if (xfer_s && last_beat(32'(count_q), 32'(len_q))) begin
          state_d = ST_FLUSH;
        end else begin
          state_d = ST_LOAD;
        end
      end
      ST_FLUSH: begin
        state_d = abort ? ST_IDLE : ST_DONE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    ready_d   = (state_d == ST_LOAD);
    busy_d    = (state_d == ST_LOAD) || (state_d == ST_FLUSH);
    done_d    = (state_d == ST_DONE);
    wr_we_s   = xfer_s;
    wr_addr_s = base_q + ADDR_W'(count_q);
  end

  // State, latched load parameters and registered status outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      base_q  <= {ADDR_W{1'b0}};
      len_q   <= {LEN_W{1'b0}};
      count_q <= {LEN_W{1'b0}};
      ready_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      base_q  <= base_d;
      len_q   <= len_d;
      count_q <= count_d;
      ready_q <= ready_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  mem_wr_stage #(
    .ADDR_W (ADDR_W)
  ) u_wr (
    .clk      (clk),
    .rst      (rst),
    .we_i     (wr_we_s),
    .addr_i   (wr_addr_s),
    .din_i    (s_data),
    .mem_we   (mem_we),
    .mem_addr (mem_addr),
    .mem_din  (mem_din)
  );

  assign s_ready = ready_q;
  assign busy    = busy_q;
  assign done    = done_q;
  assign count   = count_q;

endmodule
